// File: rtl/sb_rx_pkt_engine.sv
// rtl/sb_rx_pkt_engine.sv - sideband receive engine: pattern detect, message decode, message FIFO
//
// Purpose:
//   Takes 64-bit deserialised sideband words and either looks for the start
//   pattern (pattern mode) or decodes header / data messages. Good messages go
//   into a first-word-fall-through FIFO with a registered head toward the
//   consumer; bad ones are reported with one-cycle pulses.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_pattern_mode          1 = pattern-detect mode, 0 = message decode
//   i_word_valid, i_word    one-cycle strobe and 64-bit word from the deserialiser
//   o_pattern_detected      pulse on the 2nd consecutive PATTERN word
//   o_msg_valid/i_msg_ready FIFO head handshake
//   o_msg_*                 decoded fields of the FIFO head
//   o_parity_error          pulse, message discarded
//   o_unsup_opcode          pulse, header discarded
//   o_timeout               pulse, partial message discarded
//   o_drop_cnt              saturating count of messages dropped on FIFO overflow
//   o_fifo_level            occupied FIFO entries (0..FIFO_DEPTH)

module sb_rx_pkt_engine #(
   parameter int          DATA_BEATS  = 1,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          TIMEOUT_CYC = 32,
   parameter logic [63:0] PATTERN     = 64'hAAAA_AAAA_AAAA_AAAA
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_pattern_mode,
   input  logic                           i_word_valid,
   input  logic [63:0]                    i_word,
   output logic                           o_pattern_detected,
   output logic                           o_msg_valid,
   input  logic                           i_msg_ready,
   output logic [4:0]                     o_msg_opcode,
   output logic [7:0]                     o_msg_code,
   output logic [7:0]                     o_msg_subcode,
   output logic [15:0]                    o_msg_info,
   output logic                           o_msg_has_data,
   output logic [64*DATA_BEATS-1:0]       o_msg_data,
   output logic                           o_parity_error,
   output logic                           o_unsup_opcode,
   output logic                           o_timeout,
   output logic [7:0]                     o_drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level
);

   localparam int DW = 64 * DATA_BEATS;
   // opcode(5) + code(8) + subcode(8) + info(16) + has_data(1) + payload
   localparam int MW = 38 + DW;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

   localparam logic [4:0] OP_NODATA = 5'b10010;
   localparam logic [4:0] OP_DATA   = 5'b11011;

   typedef enum logic [1:0] {S_HDR, S_DATA, S_PAT} state_t;

   state_t          state;
   logic [63:0]     hdr;
   logic [CW-1:0]   beat_cnt;
   logic [DW-1:0]   data_buf;
   logic            dxor;
   logic [7:0]      idle_cnt;
   logic [1:0]      pat_cnt;
   logic            push_req;
   logic [MW-1:0]   push_msg;

   // ---------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------
   logic            nodata_ok;
   logic            data_ok;
   logic            is_final;
   logic [DW-1:0]   data_full;

   always_comb begin
      nodata_ok = (i_word[62] == ^i_word[61:0]) && !i_word[63];
      // Final beat is not yet in data_buf / dxor, so fold it in here.
      data_ok   = (hdr[62] == ^hdr[61:0]) && (hdr[63] == (dxor ^ (^i_word)));
      is_final  = (beat_cnt == CW'(DATA_BEATS - 1));
      data_full = data_buf;
      for (int b = 0; b < DATA_BEATS; b++) begin
         if (beat_cnt == CW'(b)) data_full[b*64 +: 64] = i_word;
      end
   end

   // ---------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state              <= S_HDR;
         hdr                <= '0;
         beat_cnt           <= '0;
         data_buf           <= '0;
         dxor               <= 1'b0;
         idle_cnt           <= '0;
         pat_cnt            <= '0;
         push_req           <= 1'b0;
         push_msg           <= '0;
         o_pattern_detected <= 1'b0;
         o_parity_error     <= 1'b0;
         o_unsup_opcode     <= 1'b0;
         o_timeout          <= 1'b0;
      end else begin
         push_req           <= 1'b0;
         o_pattern_detected <= 1'b0;
         o_parity_error     <= 1'b0;
         o_unsup_opcode     <= 1'b0;
         o_timeout          <= 1'b0;

         if (i_pattern_mode) begin
            // Pattern mode overrides everything; any partial message is
            // silently abandoned by simply leaving DATA.
            state    <= S_PAT;
            idle_cnt <= '0;
            if (i_word_valid) begin
               if (i_word == PATTERN) begin
                  if (pat_cnt == 2'd1) o_pattern_detected <= 1'b1;
                  if (pat_cnt != 2'd2) pat_cnt <= pat_cnt + 2'd1;
               end else begin
                  pat_cnt <= '0;
               end
            end
         end else begin
            pat_cnt <= '0;
            case (state)
               S_DATA: begin
                  if (i_word_valid) begin
                     idle_cnt <= '0;
                     dxor     <= dxor ^ (^i_word);
                     beat_cnt <= beat_cnt + CW'(1);
                     for (int b = 0; b < DATA_BEATS; b++) begin
                        if (beat_cnt == CW'(b)) data_buf[b*64 +: 64] <= i_word;
                     end
                     if (is_final) begin
                        state <= S_HDR;
                        if (data_ok) begin
                           push_req <= 1'b1;
                           push_msg <= {hdr[4:0], hdr[21:14], hdr[39:32],
                                        hdr[55:40], 1'b1, data_full};
                        end else begin
                           o_parity_error <= 1'b1;
                        end
                     end
                  end else if (idle_cnt == 8'(TIMEOUT_CYC - 1)) begin
                     // A strobe in this cycle would have taken the branch above.
                     o_timeout <= 1'b1;
                     idle_cnt  <= '0;
                     state     <= S_HDR;
                  end else begin
                     idle_cnt <= idle_cnt + 8'd1;
                  end
               end

               default: begin
                  // S_HDR, and S_PAT on the cycle pattern mode drops.
                  state <= S_HDR;
                  if (i_word_valid) begin
                     if (i_word[4:0] == OP_NODATA) begin
                        if (nodata_ok) begin
                           push_req <= 1'b1;
                           push_msg <= {i_word[4:0], i_word[21:14], i_word[39:32],
                                        i_word[55:40], 1'b0, {DW{1'b0}}};
                        end else begin
                           o_parity_error <= 1'b1;
                        end
                     end else if (i_word[4:0] == OP_DATA) begin
                        hdr      <= i_word;
                        beat_cnt <= '0;
                        dxor     <= 1'b0;
                        idle_cnt <= '0;
                        state    <= S_DATA;
                     end else begin
                        o_unsup_opcode <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------
   // Message FIFO with registered head
   // ---------------------------------------------------------------
   logic [MW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          head_valid;
   logic [MW-1:0] head;
   logic          full;
   logic          do_pop;
   logic          do_push;
   logic          drop;

   always_comb begin
      full    = (o_fifo_level == LW'(FIFO_DEPTH));
      do_pop  = head_valid && i_msg_ready;
      do_push = push_req && (!full || do_pop);
      drop    = push_req && full && !do_pop;
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= push_msg;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_level <= '0;
         o_drop_cnt   <= '0;
         head_valid   <= 1'b0;
         head         <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({do_push, do_pop})
            2'b10:   o_fifo_level <= o_fifo_level + LW'(1);
            2'b01:   o_fifo_level <= o_fifo_level - LW'(1);
            default: o_fifo_level <= o_fifo_level;
         endcase

         if (drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;

         // The head entry stays counted in the level until popped; the next
         // entry is loaded into the head register on the following cycle.
         if (do_pop) begin
            head_valid <= 1'b0;
         end else if (!head_valid && (o_fifo_level != '0)) begin
            head_valid <= 1'b1;
            head       <= mem[rd_ptr];
         end
      end
   end

   assign o_msg_valid    = head_valid;
   assign o_msg_opcode   = head[MW-1  -: 5];
   assign o_msg_code     = head[MW-6  -: 8];
   assign o_msg_subcode  = head[MW-14 -: 8];
   assign o_msg_info     = head[MW-22 -: 16];
   assign o_msg_has_data = head[DW];
   assign o_msg_data     = head[DW-1:0];

endmodule
